// File: rtl/sr_ctrl_pkg.sv
// rtl/sr_ctrl_pkg.sv - shared types and constants for the shift-register transmit controller
//   DIV_CNT_W  : width of the per-bit hold counter
//   sr_sel_e   : register select encoding driven onto sr_sel
//   sr_state_e : sequencer FSM states
package sr_ctrl_pkg;

  localparam int DIV_CNT_W = 8;

  typedef enum logic [1:0] {
    SEL_HOLD  = 2'b00,
    SEL_LOAD  = 2'b01,
    SEL_SHIFT = 2'b10
  } sr_sel_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LOAD    = 2'b01,
    HOLDBIT = 2'b10,
    DONE    = 2'b11
  } sr_state_e;

endpackage

// File: rtl/sr_bit_timer.sv
// rtl/sr_bit_timer.sv - per-bit hold counter with terminal-count flag
//   i_clk      : clock
//   i_rst_n    : asynchronous active-low reset
//   i_clear    : force counter to zero on the next edge (has priority over i_en)
//   i_en       : advance the counter, wrapping to zero after DIV-1
//   o_tick     : counter currently equals DIV-1
//   o_tick_nxt : counter will equal DIV-1 after the coming edge
module sr_bit_timer
  import sr_ctrl_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick,
  output logic o_tick_nxt
);

  localparam logic [DIV_CNT_W-1:0] TERM = DIV_CNT_W'(DIV - 1);

  logic [DIV_CNT_W-1:0] r_cnt;
  logic [DIV_CNT_W-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clear) begin
      w_cnt_nxt = '0;
    end else if (i_en) begin
      w_cnt_nxt = (r_cnt == TERM) ? '0 : r_cnt + DIV_CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_tick     = (r_cnt == TERM);
  // The sequencer registers sr_sel, so it has to know one cycle ahead
  // whether the coming cycle is a terminal (shift) cycle.
  assign o_tick_nxt = (w_cnt_nxt == TERM);

endmodule

// File: rtl/sr_tx_sequencer.sv
// rtl/sr_tx_sequencer.sv - LOAD/SHIFT sequencer for a parallel-load shift register, LSB first
//   clk, clr            : clock, asynchronous active-low reset
//   start_valid/ready   : word handshake; data_in captured on transfer
//   sr_sel, sr_vec, sr_d: shift-register control (select, parallel vector, serial in)
//   busy, done, bit_idx : frame status
//   SR_TX_BACK2BACK_EN  : when defined, a new word may be accepted in the final
//                         bit cycle so frames run without gap cycles
module sr_tx_sequencer
  import sr_ctrl_pkg::*;
#(
  parameter int   WIDTH = 5,
  parameter int   DIV   = 2,
  parameter logic FILL  = 1'b1,
  localparam int  IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic [1:0]       sr_sel,
  output logic [WIDTH-1:0] sr_vec,
  output logic             sr_d,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] bit_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  sr_state_e        r_state;
  sr_state_e        w_state_nxt;
  sr_sel_e          r_sel;
  sr_sel_e          w_sel_nxt;
  logic [WIDTH-1:0] r_vec;
  logic             r_busy;
  logic             r_done;
  logic             w_done_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_tick;
  logic             w_tick_nxt;
  logic             w_tmr_clear;
  logic             w_tmr_en;
  logic             w_last;
  logic             w_xfer;

  sr_bit_timer #(
    .DIV (DIV)
  ) u_bit_timer (
    .i_clk      (clk),
    .i_rst_n    (clr),
    .i_clear    (w_tmr_clear),
    .i_en       (w_tmr_en),
    .o_tick     (w_tick),
    .o_tick_nxt (w_tick_nxt)
  );

  assign w_last = (r_idx == LAST_IDX);

`ifdef SR_TX_BACK2BACK_EN
  assign start_ready = (r_state == IDLE) || ((r_state == HOLDBIT) && w_last && w_tick);
`else
  assign start_ready = (r_state == IDLE);
`endif

  assign w_xfer = start_valid && start_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    w_tmr_clear = 1'b1;
    w_tmr_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_xfer) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_state_nxt = HOLDBIT;
      end
      HOLDBIT: begin
        w_tmr_clear = 1'b0;
        w_tmr_en    = 1'b1;
        if (w_tick) begin
          if (!w_last) begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end else begin
            w_done_nxt  = 1'b1;
            // w_xfer can only be set here in back-to-back builds.
            w_state_nxt = w_xfer ? LOAD : DONE;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_state_nxt inside {IDLE, LOAD}) w_idx_nxt = '0;

    // Select is registered: look ahead to what the coming cycle will be.
    // The final bit slot never shifts, so the last data bit stays on Q.
    if (w_state_nxt == LOAD) begin
      w_sel_nxt = SEL_LOAD;
    end else if ((w_state_nxt == HOLDBIT) && w_tick_nxt && (w_idx_nxt != LAST_IDX)) begin
      w_sel_nxt = SEL_SHIFT;
    end else begin
      w_sel_nxt = SEL_HOLD;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= IDLE;
      r_sel   <= SEL_HOLD;
      r_vec   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      if (w_xfer) r_vec <= data_in;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= w_done_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  assign sr_sel  = r_sel;
  assign sr_vec  = r_vec;
  assign sr_d    = FILL;
  assign busy    = r_busy;
  assign done    = r_done;
  assign bit_idx = r_idx;

endmodule
